// File: rtl/ee201_gcd_param_if.sv
// Handshake, operand and status bundle for the ee201_gcd_param binary GCD engine.
// The master modport drives operands and control. The slave modport drives the results.
interface ee201_gcd_param_if #(
   parameter int WIDTH = 8,
   parameter int CYC_W = 16
);
   localparam int CNT_W = $clog2(WIDTH) + 1;

   logic             CEN;
   logic             Start;
   logic             Ack;
   logic [WIDTH-1:0] Ain;
   logic [WIDTH-1:0] Bin;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [WIDTH-1:0] AB_GCD;
   logic [CNT_W-1:0] i_count;
   logic [CYC_W-1:0] Cycles;
   logic             Zero_in;
   logic             q_I;
   logic             q_Sub;
   logic             q_Mult;
   logic             q_Done;

   modport master (
      output CEN, Start, Ack, Ain, Bin,
      input  A, B, AB_GCD, i_count, Cycles, Zero_in, q_I, q_Sub, q_Mult, q_Done
   );

   modport slave (
      input  CEN, Start, Ack, Ain, Bin,
      output A, B, AB_GCD, i_count, Cycles, Zero_in, q_I, q_Sub, q_Mult, q_Done
   );
endinterface

// File: rtl/ee201_gcd_param.sv
// Width-generic binary (Stein) GCD engine with a Start/Ack handshake, one-hot state outputs,
// zero-operand bypass, a clock-enable freeze and a saturating count of busy cycles.
module ee201_gcd_param #(
   parameter int WIDTH = 8,
   parameter int CYC_W = 16
) (
   input logic               Clk,
   input logic               Reset_n,
   ee201_gcd_param_if.slave  bus
);
   localparam int CNT_W = $clog2(WIDTH) + 1;

   typedef enum logic [3:0] {
      S_I    = 4'b0001,
      S_SUB  = 4'b0010,
      S_MULT = 4'b0100,
      S_DONE = 4'b1000
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] gcd_q, gcd_d;
   logic [CNT_W-1:0] icnt_q, icnt_d;
   logic [CYC_W-1:0] cyc_q, cyc_d;
   logic             zero_q, zero_d;
   logic [CYC_W-1:0] cyc_inc;
   logic             zero_op;

   assign cyc_inc = (cyc_q == {CYC_W{1'b1}}) ? cyc_q : cyc_q + CYC_W'(1);
   assign zero_op = (bus.Ain == '0) || (bus.Bin == '0);

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= S_I;
         a_q     <= '0;
         b_q     <= '0;
         gcd_q   <= '0;
         icnt_q  <= '0;
         cyc_q   <= '0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         gcd_q   <= gcd_d;
         icnt_q  <= icnt_d;
         cyc_q   <= cyc_d;
         zero_q  <= zero_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      gcd_d   = gcd_q;
      icnt_d  = icnt_q;
      cyc_d   = cyc_q;
      zero_d  = zero_q;
      if (bus.CEN) begin
         case (state_q)
            S_I: begin
               if (bus.Start) begin
                  a_d    = bus.Ain;
                  b_d    = bus.Bin;
                  icnt_d = '0;
                  cyc_d  = '0;
                  zero_d = zero_op;
                  // gcd(0,x)=x and gcd(0,0)=0, so an OR gives the answer directly
                  gcd_d   = zero_op ? (bus.Ain | bus.Bin) : '0;
                  state_d = zero_op ? S_DONE : S_SUB;
               end
            end
            S_SUB: begin
               cyc_d = cyc_inc;
               if (a_q == b_q) begin
                  gcd_d   = a_q;
                  state_d = S_MULT;
               end else if (!a_q[0] && !b_q[0]) begin
                  a_d    = a_q >> 1;
                  b_d    = b_q >> 1;
                  icnt_d = icnt_q + CNT_W'(1);
               end else if (!a_q[0]) begin
                  a_d = a_q >> 1;
               end else if (!b_q[0]) begin
                  b_d = b_q >> 1;
               end else if (a_q > b_q) begin
                  a_d = a_q - b_q;
               end else begin
                  b_d = b_q - a_q;
               end
            end
            S_MULT: begin
               cyc_d = cyc_inc;
               // Restore the common powers of two stripped off during reduction
               if (icnt_q == '0) begin
                  state_d = S_DONE;
               end else begin
                  gcd_d  = gcd_q << 1;
                  icnt_d = icnt_q - CNT_W'(1);
               end
            end
            S_DONE: begin
               if (bus.Ack) begin
                  state_d = S_I;
               end
            end
            default: begin
               state_d = S_I;
            end
         endcase
      end
   end

   assign bus.A       = a_q;
   assign bus.B       = b_q;
   assign bus.AB_GCD  = gcd_q;
   assign bus.i_count = icnt_q;
   assign bus.Cycles  = cyc_q;
   assign bus.Zero_in = zero_q;
   assign bus.q_I     = state_q[0];
   assign bus.q_Sub   = state_q[1];
   assign bus.q_Mult  = state_q[2];
   assign bus.q_Done  = state_q[3];
endmodule

// File: tb/tb_ee201_gcd_param.sv
// Self-checking bench for ee201_gcd_param: 8-bit and 16-bit instances, a vector table,
// and hand-written sequences for the freeze, reset and handshake corner cases.
module tb_ee201_gcd_param;
   logic Clk;
   logic Reset_n;

   ee201_gcd_param_if #(.WIDTH(8),  .CYC_W(16)) if8 ();
   ee201_gcd_param_if #(.WIDTH(16), .CYC_W(16)) if16 ();

   ee201_gcd_param #(.WIDTH(8),  .CYC_W(16)) u8  (.Clk(Clk), .Reset_n(Reset_n), .bus(if8));
   ee201_gcd_param #(.WIDTH(16), .CYC_W(16)) u16 (.Clk(Clk), .Reset_n(Reset_n), .bus(if16));

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int n_cmp  = 0;
   int n_fail = 0;

   // Outputs of whichever instance is under test
   logic        sel;
   logic [15:0] r_a, r_b, r_gcd, r_cyc;
   logic [4:0]  r_icnt;
   logic        r_zero;
   logic [3:0]  r_st;

   always_comb begin
      if (sel) begin
         r_a    = if16.A;
         r_b    = if16.B;
         r_gcd  = if16.AB_GCD;
         r_cyc  = if16.Cycles;
         r_icnt = if16.i_count;
         r_zero = if16.Zero_in;
         r_st   = {if16.q_Done, if16.q_Mult, if16.q_Sub, if16.q_I};
      end else begin
         r_a    = {8'h00, if8.A};
         r_b    = {8'h00, if8.B};
         r_gcd  = {8'h00, if8.AB_GCD};
         r_cyc  = if8.Cycles;
         r_icnt = {1'b0, if8.i_count};
         r_zero = if8.Zero_in;
         r_st   = {if8.q_Done, if8.q_Mult, if8.q_Sub, if8.q_I};
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Exactly one state output high on every cycle out of reset, for both instances
   always @(negedge Clk) begin
      if (Reset_n) begin
         n_cmp++;
         if ($countones({if8.q_I, if8.q_Sub, if8.q_Mult, if8.q_Done}) != 1 ||
             $countones({if16.q_I, if16.q_Sub, if16.q_Mult, if16.q_Done}) != 1) begin
            n_fail++;
            $display("FAIL onehot: got %b/%b, expected one bit each",
                     {if8.q_Done, if8.q_Mult, if8.q_Sub, if8.q_I},
                     {if16.q_Done, if16.q_Mult, if16.q_Sub, if16.q_I});
         end
      end
   end

   task automatic start_op(input logic s, input logic [15:0] a, input logic [15:0] b);
      sel = s;
      if (s) begin
         if16.Ain = a; if16.Bin = b; if16.Start = 1'b1;
      end else begin
         if8.Ain = a[7:0]; if8.Bin = b[7:0]; if8.Start = 1'b1;
      end
      @(negedge Clk);
      if8.Start  = 1'b0;
      if16.Start = 1'b0;
   endtask

   task automatic wait_done(input int max_cyc, output int n);
      n = 0;
      while (!r_st[3] && n < max_cyc) begin
         @(negedge Clk);
         n++;
      end
      check("done_in_budget", {31'd0, r_st[3]}, 32'd1);
   endtask

   task automatic do_ack();
      if8.Ack = 1'b1; if16.Ack = 1'b1;
      @(negedge Clk);
      if8.Ack = 1'b0; if16.Ack = 1'b0;
      check("ack_to_qI", {28'd0, r_st}, 32'd1);
   endtask

   typedef struct {
      logic        w16;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] gcd;
      logic [15:0] cyc;
      logic        chk_cyc;
      logic        zero;
   } vec_t;

   vec_t vt[12];

   initial begin
      int n;
      logic [15:0] sa, sb, sc;

      vt[0]  = '{1'b0, 16'd24,    16'd36,   16'd12,   16'd9,  1'b1, 1'b0};
      vt[1]  = '{1'b0, 16'd5,     16'd15,   16'd5,    16'd4,  1'b1, 1'b0};
      vt[2]  = '{1'b0, 16'd0,     16'd9,    16'd9,    16'd0,  1'b1, 1'b1};
      vt[3]  = '{1'b0, 16'd0,     16'd0,    16'd0,    16'd0,  1'b1, 1'b1};
      vt[4]  = '{1'b0, 16'd9,     16'd0,    16'd9,    16'd0,  1'b1, 1'b1};
      vt[5]  = '{1'b0, 16'd128,   16'd64,   16'd64,   16'd15, 1'b1, 1'b0};
      vt[6]  = '{1'b0, 16'd200,   16'd120,  16'd40,   16'd0,  1'b0, 1'b0};
      vt[7]  = '{1'b0, 16'd255,   16'd255,  16'd255,  16'd2,  1'b1, 1'b0};
      vt[8]  = '{1'b0, 16'd13,    16'd7,    16'd1,    16'd0,  1'b0, 1'b0};
      vt[9]  = '{1'b1, 16'd65535, 16'd255,  16'd255,  16'd0,  1'b0, 1'b0};
      vt[10] = '{1'b1, 16'd1024,  16'd1024, 16'd1024, 16'd2,  1'b1, 1'b0};
      vt[11] = '{1'b1, 16'd48,    16'd18,   16'd6,    16'd0,  1'b0, 1'b0};

      sel = 1'b0;
      Reset_n = 1'b0;
      if8.CEN = 1'b1; if8.Start = 1'b0; if8.Ack = 1'b0; if8.Ain = '0; if8.Bin = '0;
      if16.CEN = 1'b1; if16.Start = 1'b0; if16.Ack = 1'b0; if16.Ain = '0; if16.Bin = '0;
      repeat (2) @(negedge Clk);

      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         #1;
         check("rst_state", {28'd0, r_st}, 32'd1);
         check("rst_A", {16'd0, r_a}, 32'd0);
         check("rst_B", {16'd0, r_b}, 32'd0);
         check("rst_gcd", {16'd0, r_gcd}, 32'd0);
         check("rst_cycles", {16'd0, r_cyc}, 32'd0);
         check("rst_icount", {27'd0, r_icnt}, 32'd0);
         check("rst_zero", {31'd0, r_zero}, 32'd0);
      end
      @(negedge Clk);
      Reset_n = 1'b1;
      @(negedge Clk);

      for (int i = 0; i < 12; i++) begin
         start_op(vt[i].w16, vt[i].a, vt[i].b);
         if (vt[i].zero)
            check($sformatf("v%0d_zero_one_edge", i), {31'd0, r_st[3]}, 32'd1);
         wait_done(1000, n);
         check($sformatf("v%0d_gcd", i), {16'd0, r_gcd}, {16'd0, vt[i].gcd});
         check($sformatf("v%0d_zero_in", i), {31'd0, r_zero}, {31'd0, vt[i].zero});
         check($sformatf("v%0d_icount", i), {27'd0, r_icnt}, 32'd0);
         if (vt[i].chk_cyc)
            check($sformatf("v%0d_cycles", i), {16'd0, r_cyc}, {16'd0, vt[i].cyc});
         $display("vec %0d: w16=%0d gcd(%0d,%0d) -> %0d cycles=%0d", i, vt[i].w16,
                  vt[i].a, vt[i].b, r_gcd, r_cyc);
         do_ack();
      end

      // Freeze with CEN=0 partway through reduction
      start_op(1'b0, 16'd24, 16'd36);
      @(negedge Clk);
      if8.CEN = 1'b0;
      sa = r_a; sb = r_b; sc = r_cyc;
      check("frz_in_sub", {28'd0, r_st}, 32'd2);
      repeat (5) @(negedge Clk);
      check("frz_A", {16'd0, r_a}, {16'd0, sa});
      check("frz_B", {16'd0, r_b}, {16'd0, sb});
      check("frz_cycles", {16'd0, r_cyc}, {16'd0, sc});
      check("frz_state", {28'd0, r_st}, 32'd2);
      if8.CEN = 1'b1;
      wait_done(100, n);
      check("frz_gcd", {16'd0, r_gcd}, 32'd12);
      check("frz_cycles_final", {16'd0, r_cyc}, 32'd9);
      $display("freeze: gcd=%0d cycles=%0d", r_gcd, r_cyc);
      do_ack();

      // Asynchronous reset while restoring powers of two
      start_op(1'b0, 16'd24, 16'd36);
      n = 0;
      while (!r_st[2] && n < 50) begin
         @(negedge Clk);
         n++;
      end
      check("reach_mult", {31'd0, r_st[2]}, 32'd1);
      #2 Reset_n = 1'b0;
      #1;
      check("arst_state", {28'd0, r_st}, 32'd1);
      check("arst_A", {16'd0, r_a}, 32'd0);
      check("arst_B", {16'd0, r_b}, 32'd0);
      check("arst_gcd", {16'd0, r_gcd}, 32'd0);
      check("arst_cycles", {16'd0, r_cyc}, 32'd0);
      check("arst_icount", {27'd0, r_icnt}, 32'd0);
      $display("async reset: state=%b gcd=%0d", r_st, r_gcd);
      @(negedge Clk);
      Reset_n = 1'b1;
      @(negedge Clk);

      // Handshake: Start/Ack during reduction are ignored
      start_op(1'b0, 16'd24, 16'd36);
      if8.Ain = 8'd5; if8.Bin = 8'd15; if8.Start = 1'b1; if8.Ack = 1'b1;
      @(negedge Clk);
      if8.Start = 1'b0; if8.Ack = 1'b0;
      check("hs_still_busy", {31'd0, r_st[3] | r_st[0]}, 32'd0);
      wait_done(100, n);
      check("hs_gcd", {16'd0, r_gcd}, 32'd12);
      check("hs_cycles", {16'd0, r_cyc}, 32'd9);
      // Start+Ack together in q_Done: only Ack acts
      if8.Ain = 8'd7; if8.Bin = 8'd7; if8.Start = 1'b1; if8.Ack = 1'b1;
      @(negedge Clk);
      if8.Ack = 1'b0;
      check("hs_both_qI", {28'd0, r_st}, 32'd1);
      check("hs_no_latch_A", {16'd0, r_a}, 32'd3);
      check("hs_result_kept", {16'd0, r_gcd}, 32'd12);
      // Start still high in q_I launches a new run
      @(negedge Clk);
      if8.Start = 1'b0;
      check("hs_held_start", {28'd0, r_st}, 32'd2);
      check("hs_held_A", {16'd0, r_a}, 32'd7);
      wait_done(100, n);
      check("hs_held_gcd", {16'd0, r_gcd}, 32'd7);
      $display("handshake: final gcd=%0d", r_gcd);
      do_ack();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/ee201_gcd_param.md
Name: ee201_gcd_param

Overview:
Parametrised, width-generic binary (Stein) GCD engine. It succeeds the fixed 8-bit ee201_GCD and keeps the same Start/Ack handshake and one-hot state outputs. New over the 8-bit version: a WIDTH parameter, zero-operand handling, a clock-enable freeze, and a saturating cycle counter for performance reporting. It sits under the lab top level, fed by switch/register operands, with its outputs driving the SSD/LED display logic.

Parameters:
WIDTH, 8, operand/result bit width (legal 4..32)
CYC_W, 16, width of the Cycles performance counter
(localparam CNT_W = $clog2(WIDTH)+1, width of i_count)

Ports:
Clk  input  1  system clock, rising edge
Reset_n  input  1  asynchronous, active-low reset
CEN  input  1  clock enable; 0 freezes all state and registers
Start  input  1  begin computation (sampled in q_I only)
Ack  input  1  acknowledge result (sampled in q_Done only)
Ain  input  WIDTH  operand A
Bin  input  WIDTH  operand B
A  output  WIDTH  working register A
B  output  WIDTH  working register B
AB_GCD  output  WIDTH  result; valid in q_Done
i_count  output  CNT_W  count of common factors of 2 removed
Cycles  output  CYC_W  enabled cycles spent in q_Sub+q_Mult, saturating
Zero_in  output  1  latched: 1 if Ain==0 or Bin==0 at Start
q_I, q_Sub, q_Mult, q_Done  output  1 each  one-hot state

Behaviour:
- Reset (Reset_n=0, async): state=q_I; A, B, AB_GCD, i_count, Cycles = 0; Zero_in = 0.
- All transitions and register updates occur on a rising Clk edge with CEN=1. With CEN=0, everything holds.
- q_I, Start=1:
  - Latch A<=Ain, B<=Bin; clear i_count and Cycles; AB_GCD<=0.
  - If Ain==0 or Bin==0: Zero_in<=1, AB_GCD<=Ain|Bin (gcd(0,x)=x, gcd(0,0)=0), go q_Done.
  - Otherwise: Zero_in<=0, go q_Sub.
- q_Sub: Cycles+1. Apply the first matching rule each cycle:
  1. A==B: AB_GCD<=A, go q_Mult.
  2. A and B both even: A>>=1, B>>=1, i_count+1.
  3. A even: A>>=1.
  4. B even: B>>=1.
  5. A>B: A<=A-B; else B<=B-A.
  - Subtraction is unsigned WIDTH-bit; operands are nonzero, so no underflow.
- q_Mult: Cycles+1.
  - If i_count==0: go q_Done.
  - Else: AB_GCD<=AB_GCD<<1, i_count-1.
  - Result never overflows, since GCD <= min(Ain,Bin).
- q_Done: all outputs hold. Ack=1 -> q_I; registers stay visible until the next Start.
- Cycles saturates at all-ones and does not wrap.
- Ignored inputs:
  - Start outside q_I.
  - Ack outside q_Done.
  - Start asserted together with Ack in q_Done: only Ack acts. A new Start must be seen in q_I.
- Start held high across q_Done->q_I: a new computation starts on the next enabled edge in q_I. Level-sensitive, by design.
- Reset_n asserted mid-computation returns to q_I immediately with reset values. No partial result is retained.
- Exactly one q_* output is high at all times after reset.

Test Plan:
- WIDTH=8, Ain=24, Bin=36, Start pulse -> 6 q_Sub cycles, 3 q_Mult cycles, q_Done with AB_GCD=12, Cycles=9, i_count=0, Zero_in=0; Ack -> q_I next edge.
- WIDTH=8, Ain=5, Bin=15 -> q_Done with AB_GCD=5, Cycles=4 (3 q_Sub + 1 q_Mult).
- WIDTH=8, Ain=0, Bin=9 -> q_Done one edge after Start, AB_GCD=9, Zero_in=1, Cycles=0. Ain=0, Bin=0 -> AB_GCD=0, Zero_in=1.
- WIDTH=16, Ain=65535, Bin=255 -> AB_GCD=255. Ain=Bin=1024 -> immediate match, AB_GCD=1024, Cycles=2 (1 q_Sub + 1 q_Mult, i_count=0).
- Ain=24, Bin=36: hold CEN=0 for 5 cycles in mid-q_Sub -> A, B, state and Cycles frozen; final result 12, Cycles=9. Then assert Reset_n=0 during q_Mult of a second run -> async return to q_I with all outputs 0.
- Handshake: Start in q_Sub ignored; Ack in q_Sub ignored; Start+Ack together in q_Done -> q_I only, with no new latch of Ain/Bin.
